hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Issue controller for the decode stage. Tracks register-file writes that have issued but not yet retired.
//  Stalls decode while an instruction reads a register that is still pending (RAW hazard).
//  Delays each issued write tag by the fixed pipeline latency, then drives the register-file write port (wb_valid/wb_addr).
// PARAMETERS
//  N_REGS      8  number of architectural registers
//  ADDR_W      3  register address width, clog2(N_REGS)
//  WB_LATENCY  3  cycles from issue to the register-file write, >=1
//  CNT_W       2  per-register in-flight counter width, clog2(WB_LATENCY+1)
// PORTS
//  clk            in   1       clock, all state updates on the rising edge
//  rst            in   1       synchronous, active-high reset
//  dec_valid      in   1       decode holds a valid instruction
//  dec_src1       in   ADDR_W  read address 1 (instruction[15:13])
//  dec_src2       in   ADDR_W  read address 2 (instruction[12:10])
//  dec_use_src1   in   1       instruction really reads src1
//  dec_use_src2   in   1       instruction really reads src2
//  dec_dst        in   ADDR_W  destination register
//  dec_reg_write  in   1       instruction writes dec_dst (RegWrite from control)
//  flush          in   1       pipeline-wide squash
//  dec_ready      out  1       no hazard; instruction may issue this cycle
//  issue          out  1       dec_valid & dec_ready
//  wb_valid       out  1       register-file write enable this cycle
//  wb_addr        out  ADDR_W  register-file write address
//  pending        out  N_REGS  bit r = register r has at least one write in flight
//  stall_cycles   out  16      only when STALL_COUNT_EN is defined
// BEHAVIOUR
//  - Reset: tag pipe, counters and stall_cycles are all 0. wb_valid=0, wb_addr=0, pending=0.
//    dec_ready is combinational, so it is 1 after reset.
//  - hazard = (use_src1 & cnt[src1]!=0) | (use_src2 & cnt[src2]!=0). dec_ready = ~hazard.
//    dec_ready is computed whether or not dec_valid is asserted.
//  - Tag pipe: a WB_LATENCY-deep shift register of {v,addr}.
//    Stage 0 loads {issue & dec_reg_write, dec_dst}. The last stage drives wb_valid/wb_addr.
//    An issue in cycle 0 produces wb_valid in cycle WB_LATENCY.
//  - Counters: cnt[dst] increments on issue with a write. cnt[wb_addr] decrements at the end of a wb_valid cycle.
//    If both hit the same register in the same cycle, the count is unchanged.
//    In-order, fixed latency gives at most WB_LATENCY writes in flight, so counters never overflow.
//  - There is no write-to-read bypass. A source stays stalled through its retire cycle and may issue the cycle after.
//  - WAW to the same register is legal. The register stays pending until its youngest write retires.
//  - flush: all tag stages and all counters clear at the next edge. wb_valid=0 from the next cycle on.
//    wb_valid in the current cycle still commits. flush has priority over a same-cycle issue.
//  - rst mid-operation behaves like flush and also clears the optional counter.
//  - Register 0 gets no special treatment.
// CONFIGURATION
//  STALL_COUNT_EN defined: stall_cycles counts cycles with dec_valid & ~dec_ready.
//    It saturates at 16'hFFFF and clears on rst.
//  STALL_COUNT_EN undefined: the stall_cycles port and its logic are absent.
// STRUCTURE
//  Shared package cpu_pkg holds N_REGS, REG_ADDR_W, typedef reg_addr_t and typedef wb_tag_t {logic v; reg_addr_t addr;}.
//  Sub-module wb_tag_pipe: parameterised WB_LATENCY-deep delay line of wb_tag_t with synchronous clear.
//  Hazard compare and counters stay in this module.
// TESTING
//  1 Reset; issue write R3 in cycle 0; from cycle 1 dec_src1=3, use_src1=1
//    -> dec_ready=0 in cycles 1-3; wb_valid=1, wb_addr=3 in cycle 3; dec_ready=1 in cycle 4.
//  2 Issue writes to R5 in cycles 0 and 1; then read R5
//    -> pending[5]=1 through cycle 4; dec_ready=1 in cycle 5.
//  3 R2 pending; instruction with src1=2, use_src1=0 -> dec_ready=1 and issue=1.
//  4 R6 retires in cycle 3 while a new write to R6 issues in cycle 3
//    -> cnt[6] stays 1 and pending[6]=1; a new wb to R6 follows in cycle 6.
//  5 Writes R1, R4 in flight; flush=1 in cycle 1
//    -> cycle 2: pending=0, dec_ready=1; no wb_valid in cycles 2-4.
//  6 STALL_COUNT_EN: hold a hazard for 3 cycles with dec_valid=1 -> stall_cycles=3; rst -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Register-file sizing and the write-back tag type used by the
//            decode-stage hazard scoreboard and its tag delay line.
// Contents : N_REGS, REG_ADDR_W, reg_addr_t, wb_tag_t {v, addr}
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int N_REGS     = 8;
  localparam int REG_ADDR_W = $clog2(N_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One in-flight register-file write: valid flag plus destination.
  typedef struct packed {
    logic      v;
    reg_addr_t addr;
  } wb_tag_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_tag_pipe
// Purpose  : DEPTH-stage delay line of write-back tags. A tag loaded at a
//            rising edge appears on tag_o DEPTH cycles after the cycle it was
//            presented on tag_i. Synchronous clear empties every stage.
// Ports    : clk    in   clock
//            rst    in   synchronous active-high reset
//            clr_i  in   synchronous clear of all stages (pipeline squash)
//            tag_i  in   tag entering stage 0
//            tag_o  out  tag leaving the last stage
// Revision : 1.0 - initial release
// ============================================================================
module wb_tag_pipe
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clr_i,
  input  wb_tag_t tag_i,
  output wb_tag_t tag_o
);

  wb_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule : wb_tag_pipe
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Decode-stage issue controller. Counts in-flight register writes
//            per architectural register, stalls decode on RAW hazards, and
//            delays each issued write tag by WB_LATENCY cycles to drive the
//            register-file write port.
// Ports    : clk, rst               clock, synchronous active-high reset
//            dec_valid_i            decode holds a valid instruction
//            dec_src1_i/src2_i      read addresses
//            dec_use_src1_i/src2_i  instruction really reads that source
//            dec_dst_i              destination register
//            dec_reg_write_i        instruction writes dec_dst_i
//            flush_i                pipeline-wide squash
//            dec_ready_o            no hazard, instruction may issue
//            issue_o                dec_valid_i & dec_ready_o
//            wb_valid_o/wb_addr_o   register-file write port
//            pending_o              per-register write-in-flight flags
//            stall_cycles_o         saturating stall counter (optional)
// Config   : STALL_COUNT_EN - when defined, adds stall_cycles_o and its
//            saturating 16-bit counter of cycles with a stalled valid
//            instruction.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int WB_LATENCY = 3,
  parameter int CNT_W      = $clog2(WB_LATENCY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid_i,
  input  reg_addr_t         dec_src1_i,
  input  reg_addr_t         dec_src2_i,
  input  logic              dec_use_src1_i,
  input  logic              dec_use_src2_i,
  input  reg_addr_t         dec_dst_i,
  input  logic              dec_reg_write_i,
  input  logic              flush_i,
  output logic              dec_ready_o,
  output logic              issue_o,
  output logic              wb_valid_o,
  output reg_addr_t         wb_addr_o,
`ifdef STALL_COUNT_EN
  output logic [15:0]       stall_cycles_o,
`endif
  output logic [N_REGS-1:0] pending_o
);

  logic [N_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                         w_hazard;
  logic                         w_issue_wr;
  wb_tag_t                      w_tag_in;
  wb_tag_t                      w_tag_out;

  // ------------------------------------------------------------------
  // Hazard detection: a source is blocked while any write to it is in
  // flight, including the cycle in which that write retires (no bypass).
  // ------------------------------------------------------------------
  assign w_hazard    = (dec_use_src1_i && (cnt_q[dec_src1_i] != '0)) ||
                       (dec_use_src2_i && (cnt_q[dec_src2_i] != '0));
  assign dec_ready_o = ~w_hazard;
  assign issue_o     = dec_valid_i & dec_ready_o;
  assign w_issue_wr  = issue_o & dec_reg_write_i;

  // ------------------------------------------------------------------
  // Tag delay line: issue in cycle 0 surfaces as wb_valid in cycle
  // WB_LATENCY. A flush empties it; the tag already on the output in the
  // flush cycle is still presented and commits.
  // ------------------------------------------------------------------
  assign w_tag_in = '{v: w_issue_wr, addr: dec_dst_i};

  wb_tag_pipe #(
    .DEPTH (WB_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush_i),
    .tag_i (w_tag_in),
    .tag_o (w_tag_out)
  );

  assign wb_valid_o = w_tag_out.v;
  assign wb_addr_o  = w_tag_out.addr;

  // ------------------------------------------------------------------
  // Per-register in-flight counters. A same-cycle increment and
  // decrement of one register cancel. In-order fixed-latency issue keeps
  // the count at or below WB_LATENCY, so no overflow guard is needed.
  // ------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        if (w_issue_wr && (dec_dst_i == reg_addr_t'(r)) &&
            !(wb_valid_o && (wb_addr_o == reg_addr_t'(r)))) begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end else if (wb_valid_o && (wb_addr_o == reg_addr_t'(r)) &&
                     !(w_issue_wr && (dec_dst_i == reg_addr_t'(r)))) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int r = 0; r < N_REGS; r++) begin
      pending_o[r] = (cnt_q[r] != '0);
    end
  end

`ifdef STALL_COUNT_EN
  // ------------------------------------------------------------------
  // Saturating stall counter; only rst clears it, flush does not.
  // ------------------------------------------------------------------
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (dec_valid_i && !dec_ready_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard. A reference model
//            keeps a list of in-flight writes with their retire cycle; the
//            driver derives ready/issue/pending from it, and a separate
//            monitor pops expected write-backs as the DUT presents them.
// Config   : STALL_COUNT_EN - also checks stall_cycles_o
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
  import cpu_pkg::*;

  localparam int L = 3;

  typedef struct packed {
    logic [2:0] addr;
    int         due;
  } wr_t;

  logic              clk;
  logic              rst;
  logic              dec_valid_i;
  reg_addr_t         dec_src1_i;
  reg_addr_t         dec_src2_i;
  logic              dec_use_src1_i;
  logic              dec_use_src2_i;
  reg_addr_t         dec_dst_i;
  logic              dec_reg_write_i;
  logic              flush_i;
  logic              dec_ready_o;
  logic              issue_o;
  logic              wb_valid_o;
  reg_addr_t         wb_addr_o;
  logic [N_REGS-1:0] pending_o;
`ifdef STALL_COUNT_EN
  logic [15:0]       stall_cycles_o;
  int                stall_exp;
`endif

  hazard_scoreboard #(
    .WB_LATENCY (L),
    .CNT_W      (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dec_valid_i     (dec_valid_i),
    .dec_src1_i      (dec_src1_i),
    .dec_src2_i      (dec_src2_i),
    .dec_use_src1_i  (dec_use_src1_i),
    .dec_use_src2_i  (dec_use_src2_i),
    .dec_dst_i       (dec_dst_i),
    .dec_reg_write_i (dec_reg_write_i),
    .flush_i         (flush_i),
    .dec_ready_o     (dec_ready_o),
    .issue_o         (issue_o),
    .wb_valid_o      (wb_valid_o),
    .wb_addr_o       (wb_addr_o),
`ifdef STALL_COUNT_EN
    .stall_cycles_o  (stall_cycles_o),
`endif
    .pending_o       (pending_o)
  );

  int  n_vec  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  wr_t inflight [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: a register is busy while any write to it has not yet retired.
  function automatic bit busy(input int a);
    foreach (inflight[i]) if (int'(inflight[i].addr) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [N_REGS-1:0] pend_model();
    logic [N_REGS-1:0] p = '0;
    foreach (inflight[i]) p[inflight[i].addr] = 1'b1;
    return p;
  endfunction

  // One decode cycle: drive inputs, check combinational outputs against the
  // model, then advance the model as the edge at the end of the cycle will.
  task automatic step(input bit v, input int s1, input int s2, input bit u1,
                      input bit u2, input int dst, input bit w, input bit fl,
                      input bit rs);
    bit exp_ready;
    @(posedge clk);
    #1;
    rst             = rs;
    dec_valid_i     = v;
    dec_src1_i      = 3'(s1);
    dec_src2_i      = 3'(s2);
    dec_use_src1_i  = u1;
    dec_use_src2_i  = u2;
    dec_dst_i       = 3'(dst);
    dec_reg_write_i = w;
    flush_i         = fl;
    #1;
    exp_ready = !((u1 && busy(s1)) || (u2 && busy(s2)));
    chk("dec_ready", int'(dec_ready_o), int'(exp_ready));
    chk("issue", int'(issue_o), int'(v && exp_ready));
    chk("pending", int'(pending_o), int'(pend_model()));
`ifdef STALL_COUNT_EN
    chk("stall_cycles", int'(stall_cycles_o), stall_exp);
    if (rs) stall_exp = 0;
    else if (v && !exp_ready && stall_exp != 32'hFFFF) stall_exp++;
`endif
    if (fl || rs) begin
      // writes retiring this very cycle still commit; younger ones vanish
      while (inflight.size() > 0 && inflight[$].due > cyc) void'(inflight.pop_back());
    end else if (v && exp_ready && w) begin
      inflight.push_back('{addr: 3'(dst), due: cyc + L});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every expected write-back must appear in its retire cycle with
  // the right address; any other wb_valid is spurious.
  always @(negedge clk) begin
    if (inflight.size() > 0 && inflight[0].due == cyc) begin
      chk("wb_valid", int'(wb_valid_o), 1);
      chk("wb_addr", int'(wb_addr_o), int'(inflight[0].addr));
      void'(inflight.pop_front());
    end else if (wb_valid_o) begin
      chk("wb_spurious", int'(wb_valid_o), 0);
    end
  end

  initial begin
`ifdef STALL_COUNT_EN
    stall_exp = 0;
`endif
    rst = 1'b1; dec_valid_i = 0; dec_src1_i = 0; dec_src2_i = 0;
    dec_use_src1_i = 0; dec_use_src2_i = 0; dec_dst_i = 0;
    dec_reg_write_i = 0; flush_i = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    chk("reset_wb_valid", int'(wb_valid_o), 0);
    chk("reset_wb_addr", int'(wb_addr_o), 0);
    chk("reset_pending", int'(pending_o), 0);

    // RAW on R3: stalled through the retire cycle, free the cycle after
    step(1, 0, 0, 0, 0, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 3, 0, 1, 0, 0, 0, 0, 0);
    idle(2);

    // WAW on R5, then read R5
    step(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(1, 0, 0, 0, 0, 5, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 5, 5, 1, 1, 0, 0, 0, 0);
    idle(2);

    // R2 pending but src1 not really used
    step(1, 0, 0, 0, 0, 2, 1, 0, 0);
    step(1, 2, 2, 0, 0, 7, 0, 0, 0);
    idle(4);

    // R6 retires while a new write to R6 issues
    step(1, 0, 0, 0, 0, 6, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 6, 1, 0, 0);
    idle(4);

    // flush with R1, R4 in flight, plus a same-cycle issue
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 1, 0);
    step(1, 1, 4, 1, 1, 0, 0, 0, 0);
    idle(3);

    // sustained stall for the optional counter, then reset clears it
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // randomized traffic with occasional flush and one mid-run reset
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0), 1'(k == 300));
    end

    idle(L + 2);
    chk("drain", inflight.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_hazard_scoreboard
`default_nettype wire
